prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streams bytes into CPU memory port A starting at BASE_ADDR, one write per accepted byte.
// Latency: 1 cycle handshake-to-write; s_ready only in RECV. Optional read-back verify: PROG_LOADER_VERIFY_EN.
module prog_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h200,
    parameter int          MAX_LEN   = 3584
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_in,
    input  logic [7:0]  mem_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] byte_count
);

`ifdef PROG_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, VRD, VCMP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
    logic unused_mem_out;
    assign unused_mem_out = ^mem_out;
`endif

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic [11:0] count_q, count_d;
    logic        error_q, error_d;
    logic        advance;
    logic [11:0] wr_addr;
    logic        at_max;

    assign wr_addr = BASE_ADDR + count_q;
    // 13-bit compare so a MAX_LEN of 4096 cannot alias to zero
    assign at_max  = (({1'b0, count_q} + 13'd1) == 13'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            count_q <= 12'h000;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        count_d   = count_q;
        error_d   = error_q;
        advance   = 1'b0;
        s_ready   = 1'b0;
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 12'h000;
        mem_in    = 8'h00;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RECV;
                    count_d = 12'h000;
                    error_d = 1'b0;
                end
            end
            RECV: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    data_d  = s_data;
                    last_d  = s_last;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_write = 1'b1;
                mem_addr  = wr_addr;
                mem_in    = data_q;
`ifdef PROG_LOADER_VERIFY_EN
                state_d   = VRD;
`else
                advance   = 1'b1;
`endif
            end
`ifdef PROG_LOADER_VERIFY_EN
            VRD: begin
                mem_en   = 1'b1;
                mem_addr = wr_addr;
                state_d  = VCMP;
            end
            VCMP: begin
                // A failed read-back leaves byte_count at the bytes already verified
                if (mem_out != data_q) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (advance) begin
            count_d = count_q + 12'd1;
            if (last_q) begin
                state_d = DONE;
            end else if (at_max) begin
                state_d = DONE;
                error_d = 1'b1;
            end else begin
                state_d = RECV;
            end
        end
    end

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a memory model and an accepted-byte scoreboard.
module tb_prog_loader;
    localparam logic [11:0] BASE = 12'h200;
    localparam int          MAXL = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_last, s_ready;
    logic        mem_en, mem_write, busy, done, error;
    logic [7:0]  s_data, mem_in, mem_out;
    logic [11:0] mem_addr, byte_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(BASE), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out),
        .busy(busy), .done(done), .error(error), .byte_count(byte_count)
    );

    // CPU memory port A: synchronous write, one-cycle read latency
    logic [7:0] mem [4096];
    bit         corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_en && mem_write) mem[mem_addr] <= mem_in;
        if (mem_en && !mem_write)
            mem_out <= (corrupt && mem_addr == 12'h201) ? 8'h00 : mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte is written exactly one cycle later at BASE + index
    logic [7:0] exp_q[$];
    bit         hs_prev = 1'b0;
    int         wr_idx  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hs_prev = 1'b0;
            wr_idx  = 0;
        end else begin
            chk("wr_timing", mem_en && mem_write, hs_prev);
            chk("ready_and_mem", s_ready && mem_en, 1'b0);
            if (mem_en && mem_write) begin
                chk("wr_addr", mem_addr, 12'(BASE + wr_idx));
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wr_data: write of %0h with no accepted byte pending", mem_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (mem_in !== e) begin
                        n_bad++;
                        $display("FAIL wr_data: got %0h expected %0h", mem_in, e);
                    end
                end
                wr_idx++;
            end
            if (start && !busy) begin
                wr_idx = 0;
                exp_q.delete();
            end
            hs_prev = s_valid && s_ready;
            if (hs_prev) exp_q.push_back(s_data);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output bit ok);
        int n;
        bit hs;
        n = 0; ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!ok && n < 20) begin
            @(negedge clk); hs = s_ready;
            @(posedge clk); #1;
            if (hs) ok = 1'b1;
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL wait_done: done still %0b after %0d cycles", done, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int w0;
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", s_ready, 0);   chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_write", mem_write, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_in", mem_in, 0);     chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);         chk("rst_error", error, 0);
        chk("rst_count", byte_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic three-byte load
        pulse_start();
        chk("t1_busy", busy, 1); chk("t1_count0", byte_count, 0);
        send(8'hA2, 0, ok); chk("t1_acc0", ok, 1);
        send(8'h1E, 0, ok); chk("t1_acc1", ok, 1);
        send(8'hF0, 1, ok); chk("t1_acc2", ok, 1);
        wait_done();
        chk("t1_done", done, 1); chk("t1_error", error, 0);
        chk("t1_count", byte_count, 3); chk("t1_busy_end", busy, 0);
        chk("t1_m200", mem[12'h200], 8'hA2);
        chk("t1_m201", mem[12'h201], 8'h1E);
        chk("t1_m202", mem[12'h202], 8'hF0);

        // Restart from DONE, stall mid-stream
        pulse_start();
        chk("t2_done_clr", done, 0); chk("t2_ready", s_ready, 1);
        send(8'h11, 0, ok);
        repeat (3) @(posedge clk); #1;
        w0 = wr_idx;
        repeat (10) @(posedge clk); #1;
        chk("t2_stall_writes", wr_idx, w0);
        chk("t2_stall_ready", s_ready, 1);
        send(8'h22, 0, ok);
        send(8'h33, 1, ok);
        wait_done();
        chk("t2_m200", mem[12'h200], 8'h11);
        chk("t2_m201", mem[12'h201], 8'h22);
        chk("t2_m202", mem[12'h202], 8'h33);
        chk("t2_count", byte_count, 3); chk("t2_error", error, 0);

        // Overflow: five bytes, no s_last
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 0, ok);
        chk("t3_5th_rejected", ok, 0);
        wait_done();
        chk("t3_done", done, 1); chk("t3_error", error, 1);
        chk("t3_ready", s_ready, 0); chk("t3_count", byte_count, 4);
        chk("t3_writes", wr_idx, 4); chk("t3_m203", mem[12'h203], 8'h43);

        // s_last on the byte that reaches MAX_LEN
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), (i == 3), ok);
        wait_done();
        chk("t4_done", done, 1); chk("t4_error", error, 0);
        chk("t4_count", byte_count, 4);

        // start ignored mid-load, then reset during WRITE
        pulse_start();
        send(8'h66, 0, ok);
        repeat (2) @(posedge clk); #1;
        pulse_start();
        chk("t5_count_kept", byte_count, 1); chk("t5_busy", busy, 1);
        send(8'h77, 0, ok);
        chk("t5_in_write", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_mem_en", mem_en, 0); chk("t5_mem_write", mem_write, 0);
        chk("t5_mem_addr", mem_addr, 0); chk("t5_mem_in", mem_in, 0);
        chk("t5_busy0", busy, 0); chk("t5_count0", byte_count, 0);
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        chk("t5_idle_done", done, 0); chk("t5_idle_ready", s_ready, 0);

`ifdef PROG_LOADER_VERIFY_EN
        // Read-back mismatch at 0x201
        corrupt = 1'b1;
        pulse_start();
        send(8'hA2, 0, ok);
        send(8'h1E, 0, ok);
        send(8'hF0, 1, ok);
        wait_done();
        chk("t6_error", error, 1); chk("t6_done", done, 1);
        chk("t6_count", byte_count, 1);
        corrupt = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
